// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the execute-stage controller and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_res;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master (
    output start, alu_control, src_a, src_b,
    input  busy, done, alu_res, zero, hi, lo, div_by_zero
  );
  modport slave (
    input  start, alu_control, src_a, src_b,
    output busy, done, alu_res, zero, hi, lo, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU; simple ops in one registered cycle, iterative MULT/DIV into HI/LO.
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise DIV/DIVU act as undefined opcodes.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] b_q, ph_q, pl_q, hi_q, lo_q, res_q;
  logic [CW-1:0] cnt_q;
  logic dv_q, neg_q, rneg_q, zero_q, dbz_q;
  logic accept, is_mul, is_div, sgn, div0;
  logic [WIDTH-1:0] a, b, ma, mb, simple, quo, rem, it_h, it_l, new_hi, new_lo;
  logic [WIDTH:0] madd;
  logic [2*WIDTH-1:0] prod;
  assign a = bus.src_a;
  assign b = bus.src_b;
  assign accept = bus.start && state_q == IDLE;
  assign is_mul = bus.alu_control[3:1] == 3'b100;
  assign sgn = !bus.alu_control[0];
  assign div0 = is_div && b == '0;
  assign ma = sgn && a[WIDTH-1] ? -a : a;
  assign mb = sgn && b[WIDTH-1] ? -b : b;
  // ph/pl hold {partial product, multiplier} or {remainder, dividend/quotient}
  assign madd = {1'b0, ph_q} + (pl_q[0] ? {1'b0, b_q} : '0);
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] dsub;
  assign is_div = bus.alu_control[3:1] == 3'b101;
  assign dsub = {ph_q, pl_q[WIDTH-1]} - {1'b0, b_q};
  assign it_h = !dv_q ? madd[WIDTH:1] : dsub[WIDTH] ? {ph_q[WIDTH-2:0], pl_q[WIDTH-1]} : dsub[WIDTH-1:0];
  assign it_l = !dv_q ? {madd[0], pl_q[WIDTH-1:1]} : {pl_q[WIDTH-2:0], !dsub[WIDTH]};
`else
  assign is_div = 1'b0;
  assign it_h = madd[WIDTH:1];
  assign it_l = {madd[0], pl_q[WIDTH-1:1]};
`endif
  assign prod = neg_q ? -{ph_q, pl_q} : {ph_q, pl_q};
  assign quo = neg_q ? -pl_q : pl_q;
  assign rem = rneg_q ? -ph_q : ph_q;
  assign new_hi = dv_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign new_lo = dv_q ? quo : prod[WIDTH-1:0];
  always_comb begin
    case (bus.alu_control)
      4'b0000: simple = a & b;
      4'b0001: simple = a | b;
      4'b0010: simple = a + b;
      4'b0110: simple = a + ~b + 1'b1;
      4'b0111: simple = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: simple = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !accept ? IDLE : (is_mul || is_div) && !div0 ? ITER : DONE;
      ITER: state_d = cnt_q == '0 ? FIX : ITER;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.done = state_q == DONE;
  end
  assign bus.alu_res = res_q;
  assign bus.zero = zero_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.div_by_zero = dbz_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      dv_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      b_q <= mb;
      ph_q <= '0;
      pl_q <= ma;
      cnt_q <= CW'(WIDTH - 1);
      dv_q <= is_div;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_q <= sgn && a[WIDTH-1];
      dbz_q <= div0;
      if (div0) begin
        hi_q <= a;
        lo_q <= '1;
        res_q <= '1;
        zero_q <= 1'b0;
      end else if (!(is_mul || is_div)) begin
        res_q <= simple;
        zero_q <= simple == '0;
      end
    end else if (state_q == ITER) begin
      cnt_q <= cnt_q - 1'b1;
      ph_q <= it_h;
      pl_q <= it_l;
    end else if (state_q == FIX) begin
      hi_q <= new_hi;
      lo_q <= new_lo;
      res_q <= new_lo;
      zero_q <= new_lo == '0;
    end
  end
endmodule
